hazard_forward_ctrl: RTL

- Control-side counterpart to the datapath forwarding and branch-compare muxes in the 5-stage pipeline.
- Tracks in-flight destination registers through the EX, MEM and WB stages.
- Generates the 2-bit selects for the EX-stage 3-to-1 operand muxes and the 1-bit selects for the ID-stage branch-comparator 2-to-1 muxes.
- Raises stall for load-use and branch-in-ID hazards, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_forward_ctrl_pkg.sv | 29 ++
 rtl/hazard_forward_ctrl_if.sv | 36 +++
 rtl/hazard_stage_slot.sv | 25 ++
 rtl/hazard_forward_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding control block: select codes, register width
// and the per-stage slot record.
package hazard_forward_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t dest;
    logic      reg_write;
    logic      mem_read;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      use_rs;
    logic      use_rt;
  } slot_t;

  // Register 0 is hardwired, so a write to it never produces a value worth forwarding.
  function automatic logic slot_writes(slot_t s, reg_addr_t r);
    return s.valid & s.reg_write & (s.dest == r) & (r != '0);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage request and forwarding/stall response bundle between the pipeline and the
// hazard/forwarding controller.
interface hazard_forward_ctrl_if import hazard_forward_ctrl_pkg::*; #(
  parameter int unsigned CNT_W = 32
) ();

  logic             id_valid;
  reg_addr_t        id_rs;
  reg_addr_t        id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_branch;
  reg_addr_t        id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_flush;
  logic [1:0]       fwd_a_ex;
  logic [1:0]       fwd_b_ex;
  logic             fwd_a_id;
  logic             fwd_b_id;
  logic             stall;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_dest,
           id_reg_write, id_mem_read, id_flush,
    input  fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, stall, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_dest,
           id_reg_write, id_mem_read, id_flush,
    output fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, stall, stall_cycles
  );

endinterface

// File: rtl/hazard_stage_slot.sv
// One pipeline-stage tracking slot: loads the upstream record each edge, or a bubble
// when i_bubble is set; cleared asynchronously by reset.
module hazard_stage_slot import hazard_forward_ctrl_pkg::*; (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_bubble,
  input  slot_t i_slot,
  output slot_t o_slot
);

  slot_t r_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_bubble) begin
      r_slot <= '0;
    end else begin
      r_slot <= i_slot;
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding-select generation for the 5-stage pipeline; tracks
// destinations in EX/MEM/WB and counts stalled cycles (saturating).
module hazard_forward_ctrl import hazard_forward_ctrl_pkg::*; #(
  parameter int unsigned CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_forward_ctrl_if.slave bus
);

  slot_t            w_id_slot;
  slot_t            w_ex;
  slot_t            w_mem;
  slot_t            w_wb;
  logic             w_stall;
  logic             w_ex_bubble;
  logic             w_ex_hit;
  logic             w_mem_hit;
  logic             w_unused;
  logic [CNT_W-1:0] r_stall_cycles;

  function automatic logic [1:0] ex_sel(slot_t mem, slot_t wb, reg_addr_t r, logic use_r);
    if (use_r && slot_writes(mem, r) && !mem.mem_read) begin
      return FWD_MEM;
    end else if (use_r && slot_writes(wb, r)) begin
      return FWD_WB;
    end
    return FWD_REG;
  endfunction

  assign w_id_slot = '{
    valid:     bus.id_valid,
    dest:      bus.id_dest,
    reg_write: bus.id_reg_write,
    mem_read:  bus.id_mem_read,
    rs:        bus.id_rs,
    rt:        bus.id_rt,
    use_rs:    bus.id_use_rs,
    use_rt:    bus.id_use_rt
  };

  assign w_ex_bubble = ~bus.id_valid | bus.id_flush | w_stall;

  hazard_stage_slot u_slot_ex (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (w_ex_bubble),
    .i_slot   (w_id_slot),
    .o_slot   (w_ex)
  );

  hazard_stage_slot u_slot_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (1'b0),
    .i_slot   (w_ex),
    .o_slot   (w_mem)
  );

  hazard_stage_slot u_slot_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (1'b0),
    .i_slot   (w_mem),
    .o_slot   (w_wb)
  );

  assign w_ex_hit  = (bus.id_use_rs & slot_writes(w_ex, bus.id_rs)) |
                     (bus.id_use_rt & slot_writes(w_ex, bus.id_rt));
  assign w_mem_hit = (bus.id_use_rs & slot_writes(w_mem, bus.id_rs)) |
                     (bus.id_use_rt & slot_writes(w_mem, bus.id_rt));

  // Branches compare in ID, so they also wait on ALU results in EX and loads in MEM.
  assign w_stall = bus.id_valid & ~bus.id_flush &
                   ((w_ex.mem_read & w_ex_hit) |
                    (bus.id_branch & w_ex_hit) |
                    (bus.id_branch & w_mem.mem_read & w_mem_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign bus.fwd_a_ex     = ex_sel(w_mem, w_wb, w_ex.rs, w_ex.use_rs);
  assign bus.fwd_b_ex     = ex_sel(w_mem, w_wb, w_ex.rt, w_ex.use_rt);
  assign bus.fwd_a_id     = bus.id_branch & bus.id_use_rs & slot_writes(w_mem, bus.id_rs) &
                            ~w_mem.mem_read;
  assign bus.fwd_b_id     = bus.id_branch & bus.id_use_rt & slot_writes(w_mem, bus.id_rt) &
                            ~w_mem.mem_read;
  assign bus.stall        = w_stall;
  assign bus.stall_cycles = r_stall_cycles;

  // Source fields of MEM/WB and WB's load flag are carried along but never consulted.
  assign w_unused = ^{w_mem.rs, w_mem.rt, w_mem.use_rs, w_mem.use_rt,
                      w_wb.rs, w_wb.rt, w_wb.use_rs, w_wb.use_rt, w_wb.mem_read};

endmodule
